// File: rtl/paddle_ctrl.sv
// Paddle controller for the Pong display path: button-driven motion with hold-to-accelerate,
// clamped to the screen, plus a zero-latency per-pixel hit test and colour output.
module paddle_ctrl #(
   parameter int unsigned AXIS        = 0,
   parameter int unsigned LEN         = 154,
   parameter int unsigned THICK       = 16,
   parameter int unsigned FIX_POS     = 454,
   parameter int unsigned RES         = 640,
   parameter int unsigned DIVISOR     = 200000,
   parameter int unsigned STEP_MIN    = 2,
   parameter int unsigned STEP_MAX    = 8,
   parameter int unsigned ACCEL_TICKS = 16,
   parameter logic [23:0] COLOR       = 24'hFF0000
) (
   input  logic        VGA_CLK,
   input  logic        reset,
   input  logic        btn_dec_n,
   input  logic        btn_inc_n,
   input  logic        center_req,
   input  logic [10:0] x_coord,
   input  logic [10:0] y_coord,
   output logic [10:0] pos,
   output logic [3:0]  speed,
   output logic        moving,
   output logic        at_min,
   output logic        at_max,
   output logic        hit,
   output logic [7:0]  pix_R,
   output logic [7:0]  pix_G,
   output logic [7:0]  pix_B
);

   localparam int unsigned CntW  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int unsigned HoldW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

   localparam logic [CntW-1:0]  CntLast  = CntW'(DIVISOR - 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(ACCEL_TICKS - 1);
   localparam logic [11:0]      PosMax   = 12'(RES - LEN);
   localparam logic [11:0]      PosMid   = 12'((RES - LEN) / 2);
   localparam logic [11:0]      LenW     = 12'(LEN);
   localparam logic [11:0]      ResW     = 12'(RES);
   localparam logic [11:0]      FixLo    = 12'(FIX_POS);
   localparam logic [11:0]      FixHi    = 12'(FIX_POS + THICK);
   localparam logic [3:0]       SpeedMin = 4'(STEP_MIN);
   localparam logic [3:0]       SpeedMax = 4'(STEP_MAX);

   typedef enum logic [1:0] {StIdle, StMoveDec, StMoveInc} state_e;

   state_e            state_q, state_d, dir_st;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic [11:0]       pos_q, pos_d;
   logic [3:0]        speed_q, speed_d;
   logic              ctr_pend_q, ctr_pend_d;
   logic              dec_meta_q, dec_sync_q, inc_meta_q, inc_sync_q;
   logic              tick, dec, inc;
   logic [11:0]       step, pos_dec, pos_inc, inc_sum;
   logic [11:0]       along, across;

   // ------------------------------------------------------------------
   // Tick divider, button synchronizers and centre-request latch
   // ------------------------------------------------------------------
   assign tick       = (cnt_q == CntLast);
   assign cnt_d      = tick ? '0 : cnt_q + CntW'(1);
   assign dec        = ~dec_sync_q;
   assign inc        = ~inc_sync_q;
   // A request landing on a tick cycle is held over for the following tick.
   assign ctr_pend_d = tick ? center_req : (ctr_pend_q | center_req);

   always_ff @(posedge VGA_CLK) begin
      if (!reset) begin
         cnt_q      <= '0;
         dec_meta_q <= 1'b1;
         dec_sync_q <= 1'b1;
         inc_meta_q <= 1'b1;
         inc_sync_q <= 1'b1;
         ctr_pend_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         dec_meta_q <= btn_dec_n;
         dec_sync_q <= dec_meta_q;
         inc_meta_q <= btn_inc_n;
         inc_sync_q <= inc_meta_q;
         ctr_pend_q <= ctr_pend_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge VGA_CLK) begin
      if (!reset) begin
         state_q <= StIdle;
         pos_q   <= PosMid;
         speed_q <= SpeedMin;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         speed_q <= speed_d;
         hold_q  <= hold_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and motion datapath
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      speed_d = speed_q;
      hold_d  = hold_q;
      dir_st  = dec ? StMoveDec : StMoveInc;
      step    = {8'd0, speed_q};
      if (tick) begin
         if (ctr_pend_q) begin
            state_d = StIdle;
            pos_d   = PosMid;
            speed_d = SpeedMin;
            hold_d  = '0;
         end else if (dec == inc) begin
            state_d = StIdle;
            speed_d = SpeedMin;
            hold_d  = '0;
         end else begin
            state_d = dir_st;
            if (state_q != dir_st) begin
               step    = {8'd0, SpeedMin};
               speed_d = SpeedMin;
               hold_d  = '0;
            end else begin
               // hold_cnt runs modulo ACCEL_TICKS so every speed level lasts ACCEL_TICKS ticks
               hold_d = (hold_q == HoldLast) ? '0 : hold_q + HoldW'(1);
               if (hold_d == HoldLast) begin
                  speed_d = (speed_q >= SpeedMax) ? SpeedMax : speed_q + 4'd1;
               end
            end
         end
      end
      pos_dec = (pos_q < step) ? 12'd0 : pos_q - step;
      inc_sum = pos_q + step + LenW;
      pos_inc = (inc_sum > ResW) ? PosMax : pos_q + step;
      if (tick && !ctr_pend_q && (dec != inc)) begin
         pos_d = dec ? pos_dec : pos_inc;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: status decode and same-cycle pixel hit/colour
   // ------------------------------------------------------------------
   always_comb begin
      along  = (AXIS == 0) ? {1'b0, x_coord} : {1'b0, y_coord};
      across = (AXIS == 0) ? {1'b0, y_coord} : {1'b0, x_coord};
      pos    = pos_q[10:0];
      speed  = speed_q;
      moving = (state_q != StIdle);
      at_min = (pos_q == 12'd0);
      at_max = (pos_q == PosMax);
      hit    = (along >= pos_q) && (along < pos_q + LenW) &&
               (across >= FixLo) && (across < FixHi);
      pix_R  = hit ? COLOR[23:16] : 8'd0;
      pix_G  = hit ? COLOR[15:8]  : 8'd0;
      pix_B  = hit ? COLOR[7:0]   : 8'd0;
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: a horizontal default paddle and a vertical paddle,
// both with a 4-cycle tick so stimulus can be aligned to tick edges by cycle counting.
module tb_paddle_ctrl;

   logic        VGA_CLK;
   logic        reset;
   logic        dec0_n, inc0_n, ctr0, dec1_n, inc1_n, ctr1;
   logic [10:0] x_coord, y_coord;
   logic [10:0] pos0, pos1;
   logic [3:0]  speed0, speed1;
   logic        moving0, at_min0, at_max0, hit0;
   logic        moving1, at_min1, at_max1, hit1;
   logic [7:0]  r0, g0, b0, r1, g1, b1;

   int n_checks = 0;
   int n_fails  = 0;

   paddle_ctrl #(.DIVISOR(4)) dut0 (
      .VGA_CLK(VGA_CLK), .reset(reset), .btn_dec_n(dec0_n), .btn_inc_n(inc0_n),
      .center_req(ctr0), .x_coord(x_coord), .y_coord(y_coord), .pos(pos0), .speed(speed0),
      .moving(moving0), .at_min(at_min0), .at_max(at_max0), .hit(hit0),
      .pix_R(r0), .pix_G(g0), .pix_B(b0)
   );

   paddle_ctrl #(.AXIS(1), .LEN(80), .FIX_POS(20), .RES(480), .DIVISOR(4)) dut1 (
      .VGA_CLK(VGA_CLK), .reset(reset), .btn_dec_n(dec1_n), .btn_inc_n(inc1_n),
      .center_req(ctr1), .x_coord(x_coord), .y_coord(y_coord), .pos(pos1), .speed(speed1),
      .moving(moving1), .at_min(at_min1), .at_max(at_max1), .hit(hit1),
      .pix_R(r1), .pix_G(g1), .pix_B(b1)
   );

   initial VGA_CLK = 1'b0;
   always #5 VGA_CLK = ~VGA_CLK;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Starts and ends 1 time unit after a tick edge.
   task automatic tick_wait(input int n);
      repeat (4 * n) @(posedge VGA_CLK);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge VGA_CLK);
      #1;
      reset = 1'b1;
   endtask

   task automatic pixel(input int unsigned x, input int unsigned y);
      x_coord = 11'(x);
      y_coord = 11'(y);
      #1;
   endtask

   initial begin
      reset   = 1'b0;
      dec0_n  = 1'b1;
      inc0_n  = 1'b1;
      ctr0    = 1'b0;
      dec1_n  = 1'b1;
      inc1_n  = 1'b1;
      ctr1    = 1'b0;
      x_coord = '0;
      y_coord = '0;
      repeat (2) @(posedge VGA_CLK);
      #1;
      reset = 1'b1;

      // Reset state and horizontal hit test
      check_eq("rst_pos", pos0, 243);
      check_eq("rst_speed", speed0, 2);
      check_eq("rst_moving", moving0, 0);
      check_eq("rst_at_min", at_min0, 0);
      check_eq("rst_at_max", at_max0, 0);
      check_eq("rst_pos1", pos1, 200);
      check_eq("rst_at_min1", at_min1, 0);
      check_eq("rst_at_max1", at_max1, 0);
      pixel(243, 454);
      check_eq("hit_left_edge", hit0, 1);
      check_eq("pix_r_hit", r0, 255);
      check_eq("pix_g_hit", g0, 0);
      check_eq("pix_b_hit", b0, 0);
      pixel(242, 454);
      check_eq("hit_left_out", hit0, 0);
      check_eq("pix_r_left_out", r0, 0);
      pixel(397, 454);
      check_eq("hit_right_out", hit0, 0);
      pixel(396, 469);
      check_eq("hit_far_corner", hit0, 1);
      pixel(300, 470);
      check_eq("hit_below", hit0, 0);
      pixel(300, 453);
      check_eq("hit_above", hit0, 0);
      pixel(0, 0);

      // Single dec tap
      dec0_n = 1'b0;
      tick_wait(1);
      check_eq("tap_pos", pos0, 241);
      check_eq("tap_moving", moving0, 1);
      check_eq("tap_speed", speed0, 2);
      dec0_n = 1'b1;
      tick_wait(1);
      check_eq("tap_rel_moving", moving0, 0);
      check_eq("tap_rel_pos", pos0, 241);
      check_eq("tap_rel_speed", speed0, 2);

      // Inc hold with acceleration
      do_reset();
      inc0_n = 1'b0;
      tick_wait(16);
      check_eq("acc16_speed", speed0, 3);
      check_eq("acc16_pos", pos0, 275);
      tick_wait(16);
      check_eq("acc32_speed", speed0, 4);
      check_eq("acc32_pos", pos0, 323);
      tick_wait(8);
      check_eq("acc40_pos", pos0, 355);
      check_eq("acc40_speed", speed0, 4);
      tick_wait(8);
      check_eq("acc48_pos", pos0, 387);
      check_eq("acc48_speed", speed0, 5);

      // Both buttons -> idle, speed back to minimum
      dec0_n = 1'b0;
      tick_wait(1);
      check_eq("both_moving", moving0, 0);
      check_eq("both_speed", speed0, 2);
      check_eq("both_pos", pos0, 387);

      // Inc hold into the upper clamp
      dec0_n = 1'b1;
      tick_wait(40);
      check_eq("max_pos", pos0, 486);
      check_eq("max_flag", at_max0, 1);
      check_eq("max_speed", speed0, 4);
      tick_wait(1);
      check_eq("max_hold_pos", pos0, 486);
      check_eq("max_hold_flag", at_max0, 1);

      // Reversal restarts at minimum speed, then dec hold into the lower clamp at top speed
      inc0_n = 1'b1;
      dec0_n = 1'b0;
      tick_wait(1);
      check_eq("rev_pos", pos0, 484);
      check_eq("rev_speed", speed0, 2);
      check_eq("rev_moving", moving0, 1);
      check_eq("rev_at_max", at_max0, 0);
      tick_wait(119);
      check_eq("min_pos", pos0, 0);
      check_eq("min_flag", at_min0, 1);
      check_eq("speed_ceiling", speed0, 8);
      dec0_n = 1'b1;

      // Walk down to pos=1 with taps, then clamp from 1
      do_reset();
      check_eq("rst2_pos", pos0, 243);
      for (int i = 0; i < 121; i++) begin
         dec0_n = 1'b0;
         tick_wait(1);
         dec0_n = 1'b1;
         tick_wait(1);
      end
      check_eq("walk_pos", pos0, 1);
      dec0_n = 1'b0;
      tick_wait(1);
      check_eq("clamp1_pos", pos0, 0);
      check_eq("clamp1_flag", at_min0, 1);
      tick_wait(1);
      check_eq("clamp1_stay", pos0, 0);
      dec0_n = 1'b1;

      // Vertical paddle: reset during inc hold
      inc1_n = 1'b0;
      tick_wait(3);
      check_eq("v_move_pos", pos1, 206);
      check_eq("v_move_moving", moving1, 1);
      reset = 1'b0;
      @(posedge VGA_CLK);
      #1;
      check_eq("v_rst_pos", pos1, 200);
      check_eq("v_rst_speed", speed1, 2);
      check_eq("v_rst_moving", moving1, 0);
      inc1_n = 1'b1;
      reset  = 1'b1;

      pixel(20, 200);
      check_eq("v_hit_corner", hit1, 1);
      check_eq("v_pix_r", r1, 255);
      check_eq("v_pix_g", g1, 0);
      check_eq("v_pix_b", b1, 0);
      pixel(36, 200);
      check_eq("v_hit_thick_out", hit1, 0);
      pixel(35, 279);
      check_eq("v_hit_far_corner", hit1, 1);
      pixel(20, 280);
      check_eq("v_hit_len_out", hit1, 0);
      pixel(20, 199);
      check_eq("v_hit_before", hit1, 0);
      check_eq("v_pix_r_out", r1, 0);
      pixel(0, 0);

      // Centre request between ticks
      inc1_n = 1'b0;
      tick_wait(2);
      check_eq("v_pre_ctr_pos", pos1, 204);
      inc1_n = 1'b1;
      ctr1   = 1'b1;
      @(posedge VGA_CLK);
      #1;
      ctr1 = 1'b0;
      check_eq("v_ctr_pending", pos1, 204);
      repeat (3) @(posedge VGA_CLK);
      #1;
      check_eq("v_ctr_pos", pos1, 200);
      check_eq("v_ctr_moving", moving1, 0);

      // Centre request on a tick cycle waits for the following tick
      inc1_n = 1'b0;
      tick_wait(2);
      check_eq("v_pre_ctr2_pos", pos1, 204);
      inc1_n = 1'b1;
      repeat (3) @(posedge VGA_CLK);
      #1;
      ctr1 = 1'b1;
      @(posedge VGA_CLK);
      #1;
      ctr1 = 1'b0;
      check_eq("v_ctr_on_tick_hold", pos1, 204);
      tick_wait(1);
      check_eq("v_ctr_on_tick_pos", pos1, 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
